// File: rtl/adler32_check.sv
// Receive-side Adler-32 verifier: folds payload bytes into {B,A},
// assembles the 4-byte trailer and reports match/error flags.
module adler32_check #(
    parameter int unsigned MOD    = 65521,
    parameter bit          TRL_BE = 1'b1,
    parameter int unsigned LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             done,
    output logic             match,
    output logic             proto_err,
    output logic             len_err,
    output logic [31:0]      calc_sum,
    output logic [31:0]      rx_sum,
    output logic [LEN_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_TRAILER,
        S_DONE
    } state_t;

    localparam logic [16:0]      MOD17   = 17'(MOD);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           r_state;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [1:0]       r_trl_idx;
    logic [31:0]      r_rx;
    logic [LEN_W-1:0] r_cnt;
    logic             r_done;
    logic             r_match;
    logic             r_proto;
    logic             r_len;

    logic             w_xfer;
    logic             w_idle;
    logic [15:0]      w_a_base;
    logic [15:0]      w_b_base;
    logic [16:0]      w_a_sum;
    logic [16:0]      w_a_mod;
    logic [16:0]      w_b_sum;
    logic [16:0]      w_b_mod;
    logic [15:0]      w_a_next;
    logic [15:0]      w_b_next;
    logic [31:0]      w_rx_next;

    assign w_xfer   = in_valid && in_ready;
    assign w_idle   = (r_state == S_IDLE);

    // A new frame folds into the seed values rather than the stale sums.
    assign w_a_base = w_idle ? 16'd1 : r_a;
    assign w_b_base = w_idle ? 16'd0 : r_b;

    assign w_a_sum  = {1'b0, w_a_base} + {9'b0, in_data};
    assign w_a_mod  = (w_a_sum >= MOD17) ? (w_a_sum - MOD17) : w_a_sum;
    assign w_a_next = w_a_mod[15:0];

    assign w_b_sum  = {1'b0, w_b_base} + {1'b0, w_a_next};
    assign w_b_mod  = (w_b_sum >= MOD17) ? (w_b_sum - MOD17) : w_b_sum;
    assign w_b_next = w_b_mod[15:0];

    assign w_rx_next = TRL_BE ? {r_rx[23:0], in_data}
                              : {in_data, r_rx[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= 16'd1;
            r_b       <= 16'd0;
            r_trl_idx <= 2'd0;
            r_rx      <= 32'd0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_proto   <= 1'b0;
            r_len     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state   <= S_IDLE;
                r_a       <= 16'd1;
                r_b       <= 16'd0;
                r_trl_idx <= 2'd0;
                r_rx      <= 32'd0;
                r_cnt     <= '0;
                r_match   <= 1'b0;
                r_proto   <= 1'b0;
                r_len     <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_xfer) begin
                            r_match   <= 1'b0;
                            r_proto   <= 1'b0;
                            r_len     <= 1'b0;
                            r_rx      <= 32'd0;
                            r_trl_idx <= 2'd0;
                            r_a       <= w_a_next;
                            r_b       <= w_b_next;
                            r_cnt     <= CNT_ONE;
                            r_state   <= in_last ? S_TRAILER : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_xfer) begin
                            r_a <= w_a_next;
                            r_b <= w_b_next;
                            if (r_cnt == CNT_MAX) begin
                                r_len <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                            if (in_last) begin
                                r_trl_idx <= 2'd0;
                                r_state   <= S_TRAILER;
                            end
                        end
                    end
                    S_TRAILER: begin
                        if (w_xfer) begin
                            r_rx      <= w_rx_next;
                            r_trl_idx <= r_trl_idx + 2'd1;
                            if (in_last) begin
                                r_proto <= 1'b1;
                            end
                            if (r_trl_idx == 2'd3) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_match <= ({r_b, r_a} == w_rx_next);
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready   = (r_state != S_DONE);
    assign done       = r_done;
    assign match      = r_match;
    assign proto_err  = r_proto;
    assign len_err    = r_len;
    assign calc_sum   = {r_b, r_a};
    assign rx_sum     = r_rx;
    assign byte_count = r_cnt;

endmodule

// File: tb/tb_adler32_check.sv
// Randomised self-checking bench for adler32_check against a
// modulo-arithmetic Adler-32 reference (BE, LE and LEN_W=4 builds).
module tb_adler32_check;

    typedef logic [7:0] byte_q_t [$];

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        in_ready, done, match, proto_err, len_err;
    logic [31:0] calc_sum, rx_sum;
    logic [15:0] byte_count;

    logic        rdy_le, done_le, match_le, perr_le, lerr_le;
    logic [31:0] calc_le, rx_le;
    logic [15:0] cnt_le;

    logic        rdy_ln, done_ln, match_ln, perr_ln, lerr_ln;
    logic [31:0] calc_ln, rx_ln;
    logic [3:0]  cnt_ln;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rdy_bad = 0;

    adler32_check dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .done(done), .match(match), .proto_err(proto_err),
        .len_err(len_err), .calc_sum(calc_sum), .rx_sum(rx_sum),
        .byte_count(byte_count)
    );

    adler32_check #(.TRL_BE(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(rdy_le),
        .in_data(in_data), .in_last(in_last),
        .done(done_le), .match(match_le), .proto_err(perr_le),
        .len_err(lerr_le), .calc_sum(calc_le), .rx_sum(rx_le),
        .byte_count(cnt_le)
    );

    adler32_check #(.LEN_W(4)) dut_ln (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(rdy_ln),
        .in_data(in_data), .in_last(in_last),
        .done(done_ln), .match(match_ln), .proto_err(perr_ln),
        .len_err(lerr_ln), .calc_sum(calc_ln), .rx_sum(rx_ln),
        .byte_count(cnt_ln)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The block may only stall the source during its DONE cycle.
    always @(negedge clk) begin
        if (rst_n && (in_ready !== !done)) n_rdy_bad++;
    end

    function automatic logic [31:0] adler_ref(input byte_q_t q);
        int unsigned a = 1;
        int unsigned b = 0;
        foreach (q[i]) begin
            a = (a + q[i]) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic byte_q_t str_q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        n = 0;
        while (!in_ready) begin
            in_valid = 1'b0;
            n++;
            if (n > 8) begin
                n_chk++; n_fail++;
                $display("FAIL ready_timeout: in_ready stuck at 0, want 1");
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input byte_q_t pl, input logic [31:0] trl,
                             input int bad_last, input bit gaps);
        for (int i = 0; i < pl.size(); i++)
            send_byte(pl[i], i == pl.size() - 1, gaps);
        for (int i = 0; i < 4; i++)
            send_byte(trl[31-8*i -: 8], i == bad_last, gaps);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; in_last = 1'b0;
        #12;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_ready: got %0b want 1", in_ready); end
        n_chk++; if ({done, match, proto_err, len_err} !== 4'b0) begin n_fail++;
            $display("FAIL rst_flags: got %b want 0000",
                     {done, match, proto_err, len_err}); end
        n_chk++; if (calc_sum !== 32'h1) begin n_fail++;
            $display("FAIL rst_calc: got %h want 00000001", calc_sum); end
        n_chk++; if (rx_sum !== 32'h0 || byte_count !== 16'h0) begin n_fail++;
            $display("FAIL rst_rx_cnt: got %h/%0d want 0/0", rx_sum, byte_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        byte_q_t pl = str_q("abc");
        logic [31:0] s = adler_ref(pl);
        run_frame(pl, 32'h024D0127, -1, 1'b0);
        n_chk++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
            $display("FAIL t1_done: got done=%0b rdy=%0b want 1/0", done, in_ready); end
        n_chk++; if (calc_sum !== 32'h024D0127 || calc_sum !== s) begin n_fail++;
            $display("FAIL t1_calc: got %h want %h", calc_sum, s); end
        n_chk++; if (match !== 1'b1 || byte_count !== 16'd3) begin n_fail++;
            $display("FAIL t1_match: got %0b/%0d want 1/3", match, byte_count); end
        n_chk++; if (match_le !== 1'b0 || rx_le !== 32'h27014D02) begin n_fail++;
            $display("FAIL t1_le: got %0b/%h want 0/27014d02", match_le, rx_le); end
        @(negedge clk);
        n_chk++; if (done !== 1'b0 || in_ready !== 1'b1 || match !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_after: got d=%0b r=%0b m=%0b want 0/1/1",
                     done, in_ready, match); end
    endtask

    task automatic test_wikipedia();
        byte_q_t pl = str_q("Wikipedia");
        run_frame(pl, 32'h11E60398, -1, 1'b0);
        n_chk++; if (match !== 1'b1 || calc_sum !== adler_ref(pl)) begin n_fail++;
            $display("FAIL t2_good: got %0b/%h want 1/%h", match, calc_sum,
                     adler_ref(pl)); end
        run_frame(pl, 32'h11E60399, -1, 1'b0);
        n_chk++; if (match !== 1'b0 || calc_sum !== 32'h11E60398) begin n_fail++;
            $display("FAIL t2_bad: got %0b/%h want 0/11e60398", match, calc_sum); end
        n_chk++; if (rx_sum !== 32'h11E60399) begin n_fail++;
            $display("FAIL t2_rx: got %h want 11e60399", rx_sum); end
    endtask

    task automatic test_wrap();
        byte_q_t pl;
        for (int i = 0; i < 1024; i++) pl.push_back(8'hFF);
        run_frame(pl, 32'h79A6FC2E, -1, 1'b0);
        n_chk++; if (calc_sum !== adler_ref(pl) || match !== 1'b1) begin n_fail++;
            $display("FAIL t3_wrap: got %h/%0b want %h/1", calc_sum, match,
                     adler_ref(pl)); end
        n_chk++; if (byte_count !== 16'd1024) begin n_fail++;
            $display("FAIL t3_cnt: got %0d want 1024", byte_count); end
        pl = {8'h00};
        run_frame(pl, 32'h00010001, -1, 1'b0);
        n_chk++; if (calc_sum !== 32'h00010001 || match !== 1'b1) begin n_fail++;
            $display("FAIL t3_zero: got %h/%0b want 00010001/1", calc_sum, match); end
    endtask

    task automatic test_le_proto();
        byte_q_t pl = str_q("abc");
        run_frame(pl, 32'h27014D02, -1, 1'b0);
        n_chk++; if (match_le !== 1'b1 || rx_le !== 32'h024D0127) begin n_fail++;
            $display("FAIL t4_le: got %0b/%h want 1/024d0127", match_le, rx_le); end
        n_chk++; if (match !== 1'b0 || proto_err !== 1'b0) begin n_fail++;
            $display("FAIL t4_be: got %0b/%0b want 0/0", match, proto_err); end
        run_frame(pl, 32'h024D0127, 2, 1'b0);
        n_chk++; if (proto_err !== 1'b1 || match !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_proto: got p=%0b m=%0b d=%0b want 1/1/1",
                     proto_err, match, done); end
        @(negedge clk);
        run_frame(pl, 32'h024D0127, -1, 1'b0);
        n_chk++; if (proto_err !== 1'b0) begin n_fail++;
            $display("FAIL t4_clear: got %0b want 0", proto_err); end
    endtask

    task automatic test_abort();
        byte_q_t pl = str_q("abc");
        int seen = 0;
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h30; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_chk++; if (seen != 0 || byte_count !== 16'd0) begin n_fail++;
            $display("FAIL t5_abort: got dones=%0d cnt=%0d want 0/0",
                     seen, byte_count); end
        n_chk++; if (calc_sum !== 32'h1 || match !== 1'b0) begin n_fail++;
            $display("FAIL t5_state: got %h/%0b want 00000001/0", calc_sum, match); end
        run_frame(pl, 32'h024D0127, -1, 1'b0);
        n_chk++; if (match !== 1'b1 || byte_count !== 16'd3) begin n_fail++;
            $display("FAIL t5_after_abort: got %0b/%0d want 1/3", match, byte_count); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) send_byte(pl[i], i == 2, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h4D, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (calc_sum !== 32'h1 || byte_count !== 16'd0 || done !== 1'b0
                     || rx_sum !== 32'h0) begin n_fail++;
            $display("FAIL t5_rst: got %h/%0d/%0b/%h want 00000001/0/0/0",
                     calc_sum, byte_count, done, rx_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL t5_rst_done: got %0b want 0", done); end
        run_frame(pl, 32'h024D0127, -1, 1'b0);
        n_chk++; if (match !== 1'b1 || calc_sum !== 32'h024D0127) begin n_fail++;
            $display("FAIL t5_after_rst: got %0b/%h want 1/024d0127",
                     match, calc_sum); end
    endtask

    task automatic test_back_to_back();
        byte_q_t pl;
        logic [31:0] s, t;
        int bad;
        n_rdy_bad = 0;
        pl = str_q("abc");
        run_frame(pl, 32'h024D0127, -1, 1'b1);
        n_chk++; if (match !== 1'b1 || calc_sum !== 32'h024D0127) begin n_fail++;
            $display("FAIL t6_abc: got %0b/%h want 1/024d0127", match, calc_sum); end
        pl = str_q("Wikipedia");
        run_frame(pl, 32'h11E60398, -1, 1'b1);
        n_chk++; if (match !== 1'b1 || byte_count !== 16'd9) begin n_fail++;
            $display("FAIL t6_wiki: got %0b/%0d want 1/9", match, byte_count); end
        for (int k = 0; k < 8; k++) begin
            pl.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                pl.push_back(8'($urandom));
            s = adler_ref(pl);
            bad = int'($urandom_range(0, 1));
            t = (bad != 0) ? (s ^ (32'h1 << $urandom_range(0, 31))) : s;
            run_frame(pl, t, -1, k[0]);
            n_chk++;
            if (calc_sum !== s || match !== (bad == 0) ||
                byte_count !== 16'(pl.size()) || rx_le !== bswap(t)) begin
                n_fail++;
                $display("FAIL t6_rand%0d: got %h/%0b/%0d/%h want %h/%0b/%0d/%h",
                         k, calc_sum, match, byte_count, rx_le,
                         s, bad == 0, pl.size(), bswap(t));
            end
        end
        n_chk++; if (n_rdy_bad != 0) begin n_fail++;
            $display("FAIL t6_ready: got %0d bad cycles want 0", n_rdy_bad); end
    endtask

    task automatic test_len();
        byte_q_t pl;
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
        run_frame(pl, adler_ref(pl), -1, 1'b0);
        n_chk++; if (lerr_ln !== 1'b1 || cnt_ln !== 4'd15) begin n_fail++;
            $display("FAIL t6_len: got %0b/%0d want 1/15", lerr_ln, cnt_ln); end
        n_chk++; if (calc_ln !== adler_ref(pl) || match_ln !== 1'b1) begin n_fail++;
            $display("FAIL t6_len_sum: got %h/%0b want %h/1", calc_ln, match_ln,
                     adler_ref(pl)); end
        n_chk++; if (len_err !== 1'b0 || byte_count !== 16'd20) begin n_fail++;
            $display("FAIL t6_len16: got %0b/%0d want 0/20", len_err, byte_count); end
        @(negedge clk);
        pl = str_q("abc");
        run_frame(pl, 32'h024D0127, -1, 1'b0);
        n_chk++; if (lerr_ln !== 1'b0 || cnt_ln !== 4'd3) begin n_fail++;
            $display("FAIL t6_len_clear: got %0b/%0d want 0/3", lerr_ln, cnt_ln); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_wikipedia();
        test_wrap();
        test_le_proto();
        test_abort();
        test_back_to_back();
        test_len();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
